histogram_dpram: RTL and testbench
==================================

Name: histogram_dpram

Overview:
True dual-port synchronous RAM, 256 x 32 by default, used as the per-bin count store of the histogram pipeline. Port A does read-modify-write (read-before-write) accumulation. Port B reads out or clears bins. Both ports share one clock. Port A write mode is READ_BEFORE_WRITE; port B write mode is NORMAL_WRITE.

Parameters:
ADDR_WIDTH, 8, address width of both ports; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 32, word width of both ports.
OUTPUT_REG, 0, 1 adds an extra output register stage on both ports (read latency 2 instead of 1).

Ports:
Interface rule: one clock; reset is asynchronous and active-high.
clk  in  1  single clock for both ports, rising edge.
rst  in  1  asynchronous, active-high reset of the read-data registers.
a_addr  in  ADDR_WIDTH  port A address.
a_wr_data  in  DATA_WIDTH  port A write data.
a_wr_en  in  1  port A write enable.
a_rd_data  out  DATA_WIDTH  port A read data.
b_addr  in  ADDR_WIDTH  port B address.
b_wr_data  in  DATA_WIDTH  port B write data.
b_wr_en  in  1  port B write enable.
b_rd_data  out  DATA_WIDTH  port B read data.

Behaviour:
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits, shared by both ports.
- Reset does not clear storage. Contents are X until written; no init file.
- Reset: asserting rst immediately forces a_rd_data, b_rd_data and any OUTPUT_REG stage to 0. While rst is high, writes are still performed and the read registers stay 0.
- Port A, each rising clk edge when not in reset:
  - a_rd_data <= mem[a_addr], the value before this edge's write.
  - If a_wr_en is 1, mem[a_addr] <= a_wr_data.
  - Read latency is 1 cycle (OUTPUT_REG=0): address presented at edge N, data valid after edge N.
- Port B, each rising clk edge when not in reset:
  - If b_wr_en is 1: mem[b_addr] <= b_wr_data, and b_rd_data holds its previous value (NORMAL_WRITE).
  - If b_wr_en is 0: b_rd_data <= mem[b_addr]. Latency is 1 cycle.
- OUTPUT_REG=1: one extra register after each read register. Latency becomes 2 cycles; the extra register is reset to 0 as well.
- Cross-port, same address, same edge:
  - A reads while B writes: a_rd_data returns the old word.
  - B reads while A writes: b_rd_data returns the old word.
  - Both ports write: port B's data is stored.
- Addresses wrap naturally. Out-of-range addresses cannot occur because they are exactly ADDR_WIDTH bits.
- No handshake. All inputs are sampled every cycle, and outputs are registered only (no combinational path from inputs to outputs).

Test Plan:
1. Reset: hold rst=1 for 200 ns, with writes issued during reset -> a_rd_data=b_rd_data=0 throughout reset. After release, read back the words written during reset and confirm they were stored.
2. Port A fill and read: write addr k = 0..255 with data 0xFFFFFFFF-k, then read addr 0..255 on A -> a_rd_data = 0xFFFFFFFF-k exactly one cycle after each address; zero mismatches.
3. A write, B read: fill via A as in scenario 2 -> reading via B returns 0xFFFFFFFF-k one cycle after each address.
4. B write, read on both ports: fill via B with 0xFFFFFFFF-k.
   - Reading via B returns the same values with 1-cycle latency.
   - Reading via A returns the same values.
   - While B writes, b_rd_data stays unchanged.
5. Read-before-write on A: set mem[5]=0x10, then A writes 0x20 to addr 5 -> a_rd_data=0x10 on that edge. The next read of addr 5 returns 0x20.
6. Collisions on addr 7 holding 0x1:
   - A writes 0x2 while B reads -> b_rd_data=0x1.
   - A and B write 0x3 and 0x4 on the same edge -> a subsequent read returns 0x4.

Source files
------------

// File: rtl/histogram_dpram.sv
// Dual-port count store for the histogram pipeline.
// Port A: read-before-write RMW port; port B: readout/clear port.
module histogram_dpram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter bit OUTPUT_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  b_wr_en,
  output logic [DATA_WIDTH-1:0] b_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] a_rd_q;
  logic [DATA_WIDTH-1:0] a_rd_d;
  logic [DATA_WIDTH-1:0] b_rd_q;
  logic [DATA_WIDTH-1:0] b_rd_d;

  // Storage keeps writing through reset; B is last so it wins a collision.
  always_ff @(posedge clk) begin
    if (a_wr_en) mem[a_addr] <= a_wr_data;
    if (b_wr_en) mem[b_addr] <= b_wr_data;
  end

  always_comb begin
    a_rd_d = mem[a_addr];
    b_rd_d = b_rd_q;
    if (!b_wr_en) b_rd_d = mem[b_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      a_rd_q <= a_rd_d;
      b_rd_q <= b_rd_d;
    end
  end

  if (OUTPUT_REG) begin : g_oreg
    logic [DATA_WIDTH-1:0] a_out_q;
    logic [DATA_WIDTH-1:0] b_out_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_out_q <= '0;
        b_out_q <= '0;
      end else begin
        a_out_q <= a_rd_q;
        b_out_q <= b_rd_q;
      end
    end

    assign a_rd_data = a_out_q;
    assign b_rd_data = b_out_q;
  end else begin : g_noreg
    assign a_rd_data = a_rd_q;
    assign b_rd_data = b_rd_q;
  end

endmodule

// File: tb/tb_histogram_dpram.sv
// Directed self-checking bench for histogram_dpram.
// Default parameters: 1-cycle read latency on both ports.
module tb_histogram_dpram;

  logic        clk;
  logic        rst;
  logic [7:0]  a_addr;
  logic [31:0] a_wr_data;
  logic        a_wr_en;
  logic [31:0] a_rd_data;
  logic [7:0]  b_addr;
  logic [31:0] b_wr_data;
  logic        b_wr_en;
  logic [31:0] b_rd_data;

  int total;
  int bad;

  histogram_dpram dut (
    .clk       (clk),
    .rst       (rst),
    .a_addr    (a_addr),
    .a_wr_data (a_wr_data),
    .a_wr_en   (a_wr_en),
    .a_rd_data (a_rd_data),
    .b_addr    (b_addr),
    .b_wr_data (b_wr_data),
    .b_wr_en   (b_wr_en),
    .b_rd_data (b_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after an edge; outputs are checked at that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_addr = 8'd10;
    a_wr_data = 32'hA5A5_0010;
    a_wr_en = 1'b1;
    b_addr = 8'd20;
    b_wr_data = 32'h5A5A_0020;
    b_wr_en = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (a_rd_data !== 32'h0 || b_rd_data !== 32'h0) begin
        bad++;
        $display("FAIL reset_out cyc=%0d a=%h b=%h want 0/0",
                 i, a_rd_data, b_rd_data);
      end
    end
    idle();
    rst = 1'b0;
    step();
    step();
    total++;
    if (a_rd_data !== 32'hA5A5_0010) begin
      bad++;
      $display("FAIL reset_wr_a got=%h want=%h", a_rd_data, 32'hA5A5_0010);
    end
    total++;
    if (b_rd_data !== 32'h5A5A_0020) begin
      bad++;
      $display("FAIL reset_wr_b got=%h want=%h", b_rd_data, 32'h5A5A_0020);
    end
  endtask

  task automatic fill_a(input logic [31:0] base);
    idle();
    for (int k = 0; k < 256; k++) begin
      a_addr = 8'(k);
      a_wr_data = base - 32'(k);
      a_wr_en = 1'b1;
      step();
    end
    idle();
  endtask

  task automatic test_a_fill_read();
    fill_a(32'hFFFF_FFFF);
    for (int k = 0; k < 256; k++) begin
      a_addr = 8'(k);
      step();
      total++;
      if (a_rd_data !== 32'hFFFF_FFFF - 32'(k)) begin
        bad++;
        $display("FAIL a_read k=%0d got=%h want=%h",
                 k, a_rd_data, 32'hFFFF_FFFF - 32'(k));
      end
    end
  endtask

  task automatic test_a_write_b_read();
    fill_a(32'hFFFF_FFFF);
    for (int k = 0; k < 256; k++) begin
      b_addr = 8'(k);
      step();
      total++;
      if (b_rd_data !== 32'hFFFF_FFFF - 32'(k)) begin
        bad++;
        $display("FAIL b_read k=%0d got=%h want=%h",
                 k, b_rd_data, 32'hFFFF_FFFF - 32'(k));
      end
    end
  endtask

  task automatic test_b_write();
    fill_a(32'h0000_0000 + 32'd255);
    for (int k = 0; k < 256; k++) begin
      b_addr = 8'(k);
      b_wr_data = 32'hFFFF_FFFF - 32'(k);
      b_wr_en = 1'b1;
      step();
      total++;
      if (b_rd_data !== 32'hFFFF_FF00) begin
        bad++;
        $display("FAIL b_hold k=%0d got=%h want=%h",
                 k, b_rd_data, 32'hFFFF_FF00);
      end
    end
    idle();
    for (int k = 0; k < 256; k++) begin
      a_addr = 8'(255 - k);
      b_addr = 8'(k);
      step();
      total++;
      if (b_rd_data !== 32'hFFFF_FFFF - 32'(k)) begin
        bad++;
        $display("FAIL bw_b_read k=%0d got=%h want=%h",
                 k, b_rd_data, 32'hFFFF_FFFF - 32'(k));
      end
      total++;
      if (a_rd_data !== 32'hFFFF_FF00 + 32'(k)) begin
        bad++;
        $display("FAIL bw_a_read k=%0d got=%h want=%h",
                 k, a_rd_data, 32'hFFFF_FF00 + 32'(k));
      end
    end
  endtask

  task automatic test_rbw_a();
    idle();
    b_addr = 8'd5;
    b_wr_data = 32'h10;
    b_wr_en = 1'b1;
    step();
    idle();
    a_addr = 8'd5;
    a_wr_data = 32'h20;
    a_wr_en = 1'b1;
    step();
    total++;
    if (a_rd_data !== 32'h10) begin
      bad++;
      $display("FAIL rbw_old got=%h want=%h", a_rd_data, 32'h10);
    end
    idle();
    step();
    total++;
    if (a_rd_data !== 32'h20) begin
      bad++;
      $display("FAIL rbw_new got=%h want=%h", a_rd_data, 32'h20);
    end
  endtask

  task automatic test_collision();
    idle();
    a_addr = 8'd7;
    b_addr = 8'd7;
    b_wr_data = 32'h1;
    b_wr_en = 1'b1;
    step();
    idle();
    a_wr_data = 32'h2;
    a_wr_en = 1'b1;
    step();
    total++;
    if (b_rd_data !== 32'h1) begin
      bad++;
      $display("FAIL col_b_old got=%h want=%h", b_rd_data, 32'h1);
    end
    total++;
    if (a_rd_data !== 32'h1) begin
      bad++;
      $display("FAIL col_a_old got=%h want=%h", a_rd_data, 32'h1);
    end
    a_wr_data = 32'h3;
    b_wr_data = 32'h4;
    b_wr_en = 1'b1;
    step();
    idle();
    step();
    total++;
    if (a_rd_data !== 32'h4) begin
      bad++;
      $display("FAIL col_ww_a got=%h want=%h", a_rd_data, 32'h4);
    end
    total++;
    if (b_rd_data !== 32'h4) begin
      bad++;
      $display("FAIL col_ww_b got=%h want=%h", b_rd_data, 32'h4);
    end
    b_wr_data = 32'h5;
    b_wr_en = 1'b1;
    step();
    total++;
    if (a_rd_data !== 32'h4) begin
      bad++;
      $display("FAIL col_a_rd_bw got=%h want=%h", a_rd_data, 32'h4);
    end
    idle();
    step();
    total++;
    if (a_rd_data !== 32'h5) begin
      bad++;
      $display("FAIL col_bw_new got=%h want=%h", a_rd_data, 32'h5);
    end
  endtask

  task automatic test_async_reset();
    idle();
    a_addr = 8'd5;
    b_addr = 8'd7;
    step();
    total++;
    if (a_rd_data !== 32'h20 || b_rd_data !== 32'h5) begin
      bad++;
      $display("FAIL pre_arst a=%h b=%h want 20/5", a_rd_data, b_rd_data);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (a_rd_data !== 32'h0 || b_rd_data !== 32'h0) begin
      bad++;
      $display("FAIL arst a=%h b=%h want 0/0", a_rd_data, b_rd_data);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (a_rd_data !== 32'h20 || b_rd_data !== 32'h5) begin
      bad++;
      $display("FAIL post_arst a=%h b=%h want 20/5", a_rd_data, b_rd_data);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    a_addr = '0;
    a_wr_data = '0;
    a_wr_en = 1'b0;
    b_addr = '0;
    b_wr_data = '0;
    b_wr_en = 1'b0;
    test_reset();
    test_a_fill_read();
    test_a_write_b_read();
    test_b_write();
    test_rbw_a();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
